ofs_plat_avalon_mem_bank_responder: RTL and testbench

Simulation and bring-up responder for the far end of one local-memory bank. The AFU drives a bank as an Avalon-MM initiator; this block answers it in place of a real memory controller. It backs the bank with a small word-addressed RAM and supports bursts, byte enables, waitrequest flow control and a fixed read latency. It pairs with the bank tie-off: the tie-off quiets an unused FIU-side bank, and this block stands in for an absent one.

---
 rtl/ofs_plat_avalon_mem_bank_responder.sv | 156 +++++++++++++++
 tb/tb_ofs_plat_avalon_mem_bank_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ofs_plat_avalon_mem_bank_responder.sv
// Avalon-MM responder standing in for an absent local-memory bank: a small
// word-addressed RAM with bursts, byte enables, waitrequest and fixed read latency.
module ofs_plat_avalon_mem_bank_responder #(
  parameter int ADDR_WIDTH      = 10,
  parameter int DATA_WIDTH      = 64,
  parameter int BURST_CNT_WIDTH = 4,
  parameter int READ_LATENCY    = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [ADDR_WIDTH-1:0]      avs_address,
  input  logic [BURST_CNT_WIDTH-1:0] avs_burstcount,
  input  logic                       avs_read,
  input  logic                       avs_write,
  input  logic [DATA_WIDTH-1:0]      avs_writedata,
  input  logic [DATA_WIDTH/8-1:0]    avs_byteenable,
  output logic                       avs_waitrequest,
  output logic [DATA_WIDTH-1:0]      avs_readdata,
  output logic                       avs_readdatavalid,
  output logic                       protocol_err
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int DEPTH    = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [ADDR_WIDTH-1:0]      wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0]      rd_addr_q, rd_addr_d;
  logic [BURST_CNT_WIDTH-1:0] remaining_q, remaining_d;
  logic                       waitreq_q;
  logic                       perr_q, perr_d;

  logic                       mem_we;
  logic [ADDR_WIDTH-1:0]      mem_waddr;
  logic                       rd_issue;
  logic [BURST_CNT_WIDTH-1:0] burst_len;
  logic [DATA_WIDTH-1:0]      ram_rdata;

  // A zero burstcount is served as a single beat (and flagged below).
  assign burst_len = (avs_burstcount == '0) ? BURST_CNT_WIDTH'(1) : avs_burstcount;

  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    remaining_d = remaining_q;
    perr_d      = perr_q;
    mem_we      = 1'b0;
    mem_waddr   = avs_address;
    rd_issue    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!waitreq_q) begin
          if (avs_write) begin
            mem_we    = 1'b1;
            mem_waddr = avs_address;
            if (avs_burstcount == '0) perr_d = 1'b1;
            // Simultaneous read is dropped in favour of the write.
            if (avs_read) perr_d = 1'b1;
            if (burst_len > BURST_CNT_WIDTH'(1)) begin
              wr_addr_d   = avs_address + ADDR_WIDTH'(1);
              remaining_d = burst_len - BURST_CNT_WIDTH'(1);
              state_d     = WR_BURST;
            end
          end else if (avs_read) begin
            if (avs_burstcount == '0) perr_d = 1'b1;
            rd_addr_d   = avs_address;
            remaining_d = burst_len;
            state_d     = RD_BURST;
          end
        end
      end

      WR_BURST: begin
        if (avs_read) perr_d = 1'b1;
        if (avs_write) begin
          mem_we      = 1'b1;
          mem_waddr   = wr_addr_q;
          wr_addr_d   = wr_addr_q + ADDR_WIDTH'(1);
          remaining_d = remaining_q - BURST_CNT_WIDTH'(1);
          if (remaining_q <= BURST_CNT_WIDTH'(1)) state_d = IDLE;
        end
      end

      RD_BURST: begin
        rd_issue    = 1'b1;
        rd_addr_d   = rd_addr_q + ADDR_WIDTH'(1);
        remaining_d = remaining_q - BURST_CNT_WIDTH'(1);
        if (remaining_q <= BURST_CNT_WIDTH'(1)) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // waitrequest is decoded from the next state so it is already high in the
  // cycle right after a read is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      remaining_q <= '0;
      waitreq_q   <= 1'b1;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      remaining_q <= remaining_d;
      waitreq_q   <= (state_d == RD_BURST);
      perr_q      <= perr_d;
    end
  end

  // One narrow RAM per byte lane so byte enables map onto plain lane writes.
  for (genvar gi = 0; gi < BE_WIDTH; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    logic [7:0] lane_rdata_q;

    always_ff @(posedge clk) begin
      if (mem_we && avs_byteenable[gi]) lane_mem[mem_waddr] <= avs_writedata[gi*8 +: 8];
      if (rd_issue) lane_rdata_q <= lane_mem[rd_addr_q];
    end

    assign ram_rdata[gi*8 +: 8] = lane_rdata_q;
  end

  // vld_q[0] marks the registered RAM output; stages 1..READ_LATENCY delay it.
  logic [READ_LATENCY:0]  vld_q;
  logic [DATA_WIDTH-1:0]  dat_q [1:READ_LATENCY];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int s = 1; s <= READ_LATENCY; s++) dat_q[s] <= '0;
    end else begin
      vld_q    <= {vld_q[READ_LATENCY-1:0], rd_issue};
      dat_q[1] <= ram_rdata;
      for (int s = 2; s <= READ_LATENCY; s++) dat_q[s] <= dat_q[s-1];
    end
  end

  assign avs_waitrequest   = waitreq_q;
  assign avs_readdatavalid = vld_q[READ_LATENCY];
  assign avs_readdata      = dat_q[READ_LATENCY];
  assign protocol_err      = perr_q;

endmodule

// File: tb/tb_ofs_plat_avalon_mem_bank_responder.sv
// Directed bench for the bank responder: writes, bursts, byte enables, wrap,
// protocol errors and reset in the middle of a read burst.
module tb_ofs_plat_avalon_mem_bank_responder;
  localparam int AW = 10;
  localparam int DW = 64;
  localparam int BW = 4;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] avs_address = '0;
  logic [BW-1:0] avs_burstcount = '0;
  logic          avs_read = 1'b0;
  logic          avs_write = 1'b0;
  logic [DW-1:0] avs_writedata = '0;
  logic [7:0]    avs_byteenable = '0;
  logic          avs_waitrequest;
  logic [DW-1:0] avs_readdata;
  logic          avs_readdatavalid;
  logic          protocol_err;

  always #5 clk = ~clk;

  ofs_plat_avalon_mem_bank_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .avs_address(avs_address), .avs_burstcount(avs_burstcount),
    .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_waitrequest(avs_waitrequest), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid), .protocol_err(protocol_err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Beats and waitrequest-high cycles observed on the falling edge.
  logic [DW-1:0] rq_data[$];
  int            rq_cyc[$];
  int            wr_hi = 0;
  always @(negedge clk) begin
    if (avs_readdatavalid) begin
      rq_data.push_back(avs_readdata);
      rq_cyc.push_back(cyc);
    end
    if (reset_n && avs_waitrequest) wr_hi++;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds a request until accepted; returns the accept-edge index.
  task automatic issue(input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [BW-1:0] bc, input logic [DW-1:0] d,
                       input logic [7:0] be, output int acc);
    int n;
    n = 0;
    avs_read = rd; avs_write = wr; avs_address = a; avs_burstcount = bc;
    avs_writedata = d; avs_byteenable = be;
    while (avs_waitrequest === 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) chk("accept_timeout", 1, 0);
    @(posedge clk); #1;
    acc = cyc;
    avs_read = 1'b0; avs_write = 1'b0;
  endtask

  task automatic wbeat(input logic [DW-1:0] d);
    avs_write = 1'b1; avs_writedata = d; avs_byteenable = 8'hFF;
    @(posedge clk); #1;
    avs_write = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int k;
    k = 0;
    while (rq_data.size() < n && k < 100) begin
      @(posedge clk); #1; k++;
    end
    if (rq_data.size() < n) chk("beat_timeout", rq_data.size(), n);
  endtask

  // Read burst; expects n beats with values base, base+1, ...
  task automatic rd_check(input string tag, input logic [AW-1:0] a, input logic [BW-1:0] bc,
                          input int n, input logic [DW-1:0] base);
    int acc;
    rq_data.delete(); rq_cyc.delete(); wr_hi = 0;
    issue(1'b1, 1'b0, a, bc, '0, '0, acc);
    wait_beats(n);
    cycles(6);
    chk({tag, "_beats"}, rq_data.size(), n);
    chk({tag, "_wait"}, wr_hi, n);
    if (rq_data.size() > 0) chk({tag, "_lat"}, rq_cyc[0], acc + RL + 1);
    for (int i = 0; i < rq_data.size(); i++) begin
      chk($sformatf("%s_d%0d", tag, i), rq_data[i], base + DW'(i));
      if (i > 0) chk($sformatf("%s_gap%0d", tag, i), rq_cyc[i], rq_cyc[i-1] + 1);
    end
  endtask

  initial begin
    int acc;
    cycles(3);
    chk("rst_wait", avs_waitrequest, 1);
    chk("rst_valid", avs_readdatavalid, 0);
    chk("rst_data", avs_readdata, 0);
    chk("rst_perr", protocol_err, 0);
    reset_n = 1'b1;

    issue(1'b0, 1'b1, 10'h010, 4'd1, 64'h1122334455667788, 8'hFF, acc);
    rd_check("single", 10'h010, 4'd1, 1, 64'h1122334455667788);

    issue(1'b0, 1'b1, 10'h020, 4'd4, 64'hA0, 8'hFF, acc);
    wbeat(64'hA1);
    cycles(2);
    wbeat(64'hA2);
    wbeat(64'hA3);
    rd_check("burst", 10'h020, 4'd4, 4, 64'hA0);
    chk("burst_perr", protocol_err, 0);

    issue(1'b0, 1'b1, 10'h030, 4'd1, 64'hFFFFFFFFFFFFFFFF, 8'hFF, acc);
    issue(1'b0, 1'b1, 10'h030, 4'd1, 64'h0, 8'h0F, acc);
    rd_check("byteen", 10'h030, 4'd1, 1, 64'hFFFFFFFF00000000);

    issue(1'b0, 1'b1, 10'h3FE, 4'd4, 64'd1, 8'hFF, acc);
    wbeat(64'd2);
    wbeat(64'd3);
    wbeat(64'd4);
    rd_check("wrap0", 10'h3FE, 4'd1, 1, 64'd1);
    rd_check("wrap1", 10'h3FF, 4'd1, 1, 64'd2);
    rd_check("wrap2", 10'h000, 4'd1, 1, 64'd3);
    rd_check("wrap3", 10'h001, 4'd1, 1, 64'd4);
    rd_check("wrapb", 10'h3FE, 4'd4, 4, 64'd1);

    rq_data.delete(); rq_cyc.delete();
    issue(1'b1, 1'b1, 10'h040, 4'd1, 64'h55, 8'hFF, acc);
    cycles(8);
    chk("rw_noread", rq_data.size(), 0);
    chk("rw_wait", avs_waitrequest, 0);
    chk("rw_perr", protocol_err, 1);
    rd_check("rw_write", 10'h040, 4'd1, 1, 64'h55);

    reset_n = 1'b0;
    cycles(2);
    chk("rst2_perr", protocol_err, 0);
    reset_n = 1'b1;
    issue(1'b0, 1'b1, 10'h050, 4'd0, 64'h66, 8'hFF, acc);
    cycles(1);
    chk("bc0_perr", protocol_err, 1);
    chk("bc0_idle", avs_waitrequest, 0);
    rd_check("bc0_read", 10'h050, 4'd0, 1, 64'h66);
    rd_check("retain", 10'h010, 4'd1, 1, 64'h1122334455667788);

    issue(1'b0, 1'b1, 10'h100, 4'd8, 64'h100, 8'hFF, acc);
    for (int i = 1; i < 8; i++) wbeat(64'h100 + 64'(i));
    rq_data.delete(); rq_cyc.delete();
    issue(1'b1, 1'b0, 10'h100, 4'd8, '0, '0, acc);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("mid_valid", avs_readdatavalid, 0);
    chk("mid_wait", avs_waitrequest, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("mid_hold%0d", i), avs_readdatavalid, 0);
    end
    reset_n = 1'b1;
    cycles(8);
    chk("mid_nobeats", rq_data.size(), 0);
    chk("mid_perr", protocol_err, 0);
    rd_check("post_rst", 10'h100, 4'd8, 8, 64'h100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
